// File: rtl/router_pkg.sv
// Shared definitions for the 1-to-3 router: packet address format and the
// controller state encoding.
package router_pkg;

   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned NUM_DEST = 3;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   // Controller phases; DECODE_ADDRESS is the idle/reset phase.
   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } ctrl_state_e;

   // Picks the per-destination flag for an address; the invalid address
   // maps to no destination and yields 0.
   function automatic logic dest_bit(input logic [NUM_DEST-1:0] vec,
                                     input logic [ADDR_W-1:0]   addr);
      case (addr)
         2'd0:    return vec[0];
         2'd1:    return vec[1];
         2'd2:    return vec[2];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-level controller for the router input path. Decodes the header
// address, sequences header/payload/parity phases and handles full, busy
// destination and per-destination soft-reset conditions. All outputs are
// Moore decodes of the state register.
module router_ctrl_fsm
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              fifo_empty_0,
   input  logic              fifo_empty_1,
   input  logic              fifo_empty_2,
   input  logic              soft_reset_0,
   input  logic              soft_reset_1,
   input  logic              soft_reset_2,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              write_enb_reg,
   output logic              rst_int_reg,
   output logic              busy
);

   ctrl_state_e         state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NUM_DEST-1:0] empty_vec;
   logic [NUM_DEST-1:0] soft_vec;
   logic                sel_empty;
   logic                sel_soft;

   assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

   // Flags of the destination latched from the current packet header.
   assign sel_empty = dest_bit(empty_vec, addr_q);
   assign sel_soft  = dest_bit(soft_vec, addr_q);

   // State and address registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state and header-address capture.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_d = state_q;
      addr_d  = addr_q;

      if (state_q == DECODE_ADDRESS && pkt_valid) begin
         addr_d = data_in;
      end

      if (state_q != DECODE_ADDRESS && sel_soft) begin
         // Timeout of the addressed destination aborts the packet.
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               // The header address is not registered yet, so use data_in.
               if (pkt_valid && data_in != ADDR_INVALID) begin
                  state_d = dest_bit(empty_vec, data_in) ? LOAD_FIRST_DATA
                                                         : WAIT_TILL_EMPTY;
               end
            end
            WAIT_TILL_EMPTY: begin
               if (sel_empty) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)        state_d = DECODE_ADDRESS;
               else if (low_pkt_valid) state_d = LOAD_PARITY;
               else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Moore output decode from the state register only.
   always_comb begin
      detect_add    = (state_q == DECODE_ADDRESS);
      lfd_state     = (state_q == LOAD_FIRST_DATA);
      ld_state      = (state_q == LOAD_DATA);
      laf_state     = (state_q == LOAD_AFTER_FULL);
      full_state    = (state_q == FIFO_FULL_STATE);
      write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                      (state_q == LOAD_AFTER_FULL);
      rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
      busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
   end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: directed packet scenarios with
// literal output expectations, then randomized traffic compared every cycle
// against a phase-level behavioural model.
module tb_router_ctrl_fsm;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done, low_pkt_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;

   int vectors     = 0;
   int miscompares = 0;

   // Model: packet phase name and the destination latched from the header.
   string      m_ph;
   logic [1:0] m_addr;

   always #5 clock = ~clock;

   router_ctrl_fsm dut (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .write_enb_reg (write_enb_reg),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy)
   );

   // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
   localparam logic [7:0] O_DA  = 8'h80;
   localparam logic [7:0] O_LFD = 8'h41;
   localparam logic [7:0] O_LD  = 8'h24;
   localparam logic [7:0] O_LAF = 8'h15;
   localparam logic [7:0] O_FFS = 8'h09;
   localparam logic [7:0] O_LP  = 8'h05;
   localparam logic [7:0] O_CPE = 8'h03;
   localparam logic [7:0] O_WTE = 8'h01;

   function automatic logic [7:0] dut_out();
      return {detect_add, lfd_state, ld_state, laf_state, full_state,
              write_enb_reg, rst_int_reg, busy};
   endfunction

   // Expected outputs of a phase, straight from the port descriptions.
   function automatic logic [7:0] phase_out(input string ph);
      logic da, lfd, ld, laf, ffs, lp, cpe;
      da  = (ph == "DA");  lfd = (ph == "LFD"); ld = (ph == "LD");
      laf = (ph == "LAF"); ffs = (ph == "FFS"); lp = (ph == "LP");
      cpe = (ph == "CPE");
      return {da, lfd, ld, laf, ffs, ld | lp | laf, cpe, !(da | ld)};
   endfunction

   function automatic bit pick(input bit v0, input bit v1, input bit v2,
                               input logic [1:0] a);
      if (a == 2'd0) return v0;
      if (a == 2'd1) return v1;
      if (a == 2'd2) return v2;
      return 1'b0;
   endfunction

   // Advance the model by one clock edge using the current inputs.
   task automatic model_edge();
      string nx;
      bit    s_empty, s_soft;
      if (!resetn) begin
         m_ph   = "DA";
         m_addr = 2'd0;
         return;
      end
      s_empty = pick(fifo_empty_0, fifo_empty_1, fifo_empty_2, m_addr);
      s_soft  = pick(soft_reset_0, soft_reset_1, soft_reset_2, m_addr);
      nx = m_ph;
      if (m_ph != "DA" && s_soft) nx = "DA";
      else if (m_ph == "DA") begin
         if (pkt_valid && data_in != 2'b11)
            nx = pick(fifo_empty_0, fifo_empty_1, fifo_empty_2, data_in) ? "LFD" : "WTE";
      end
      else if (m_ph == "WTE") nx = s_empty ? "LFD" : "WTE";
      else if (m_ph == "LFD") nx = "LD";
      else if (m_ph == "LD")  nx = fifo_full ? "FFS" : (!pkt_valid ? "LP" : "LD");
      else if (m_ph == "FFS") nx = fifo_full ? "FFS" : "LAF";
      else if (m_ph == "LAF") nx = parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
      else if (m_ph == "LP")  nx = "CPE";
      else if (m_ph == "CPE") nx = fifo_full ? "FFS" : "DA";
      if (m_ph == "DA" && pkt_valid) m_addr = data_in;
      m_ph = nx;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at t=%0t: outputs=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // One clock: model follows the edge, DUT compared on the falling edge.
   task automatic step(input string name);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check(name, dut_out(), phase_out(m_ph));
   endtask

   // Step and additionally pin the outputs to a hand-computed literal.
   task automatic step_lit(input string name, input logic [7:0] lit);
      step(name);
      check({name, "_lit"}, dut_out(), lit);
   endtask

   task automatic quiet();
      pkt_valid = 0; data_in = 0; fifo_full = 0;
      fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
      soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
      parity_done = 0; low_pkt_valid = 0;
   endtask

   initial begin
      m_ph = "DA"; m_addr = 0;
      quiet();
      resetn = 0;
      step_lit("reset", O_DA);
      step_lit("reset2", O_DA);
      resetn = 1;

      // Idle with no packet.
      for (int i = 0; i < 5; i++) step_lit("idle", O_DA);

      // Packet to dest 1: header, 3 payload, parity.
      pkt_valid = 1; data_in = 2'b01;
      step_lit("p1_lfd", O_LFD);
      data_in = 2'b00;
      step_lit("p1_ld1", O_LD);
      step_lit("p1_ld2", O_LD);
      step_lit("p1_ld3", O_LD);
      pkt_valid = 0;
      step_lit("p1_lp", O_LP);
      step_lit("p1_cpe", O_CPE);
      step_lit("p1_da", O_DA);

      // Packet to busy dest 2 waits, then header, then full handling.
      pkt_valid = 1; data_in = 2'b10; fifo_empty_2 = 0;
      for (int i = 0; i < 4; i++) step_lit("p2_wte", O_WTE);
      fifo_empty_2 = 1;
      step_lit("p2_lfd", O_LFD);
      step_lit("p2_ld", O_LD);
      fifo_full = 1;
      for (int i = 0; i < 3; i++) step_lit("p2_ffs", O_FFS);
      fifo_full = 0; low_pkt_valid = 1; pkt_valid = 0;
      step_lit("p2_laf", O_LAF);
      step_lit("p2_lp", O_LP);
      low_pkt_valid = 0;
      step_lit("p2_cpe", O_CPE);
      step_lit("p2_da", O_DA);

      // Soft reset of the addressed destination aborts the packet.
      pkt_valid = 1; data_in = 2'b00;
      step_lit("p3_lfd", O_LFD);
      step_lit("p3_ld", O_LD);
      soft_reset_0 = 1;
      step_lit("p3_soft", O_DA);
      soft_reset_0 = 0; pkt_valid = 0;
      step_lit("p3_idle", O_DA);

      // Soft reset of another destination is ignored.
      pkt_valid = 1; data_in = 2'b00;
      step_lit("p4_lfd", O_LFD);
      step_lit("p4_ld", O_LD);
      soft_reset_1 = 1;
      step_lit("p4_soft_other", O_LD);
      soft_reset_1 = 0; pkt_valid = 0;
      step_lit("p4_lp", O_LP);
      step_lit("p4_cpe", O_CPE);
      step_lit("p4_da", O_DA);

      // Invalid address is dropped.
      pkt_valid = 1; data_in = 2'b11;
      for (int i = 0; i < 3; i++) step_lit("p5_addr3", O_DA);
      quiet();
      step_lit("p5_idle", O_DA);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         resetn        = ($urandom_range(0, 99) != 0);
         pkt_valid     = ($urandom_range(0, 3) != 0);
         data_in       = 2'($urandom_range(0, 3));
         fifo_full     = ($urandom_range(0, 3) == 0);
         fifo_empty_0  = $urandom_range(0, 1) == 1;
         fifo_empty_1  = $urandom_range(0, 1) == 1;
         fifo_empty_2  = $urandom_range(0, 1) == 1;
         soft_reset_0  = ($urandom_range(0, 19) == 0);
         soft_reset_1  = ($urandom_range(0, 19) == 0);
         soft_reset_2  = ($urandom_range(0, 19) == 0);
         parity_done   = ($urandom_range(0, 3) == 0);
         low_pkt_valid = ($urandom_range(0, 3) == 0);
         step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
